// File: rtl/axi4_fifo_reader_ctrl.sv
// AXI4 read master that fetches LENGTH beats starting at BASEADDR and streams
// them, in address order, out of a first-word-fall-through FIFO. A burst is
// only issued when the FIFO has room for every beat of it, so rready can stay
// high permanently.
module axi4_fifo_reader_ctrl #(
  parameter int REGADDR_CTRL       = 0,
  parameter int REGADDR_BASEADDR_L = 4,
  parameter int REGADDR_BASEADDR_H = 8,
  parameter int REGADDR_LENGTH     = 12,
  parameter int REGADDR_STATUS     = 16,
  parameter int REGADDR_COUNT      = 20,
  parameter int CTRL_ADDR_WIDTH    = 16,
  parameter int AXI_ADDR_WIDTH     = 36,
  parameter int AXI_DATA_WIDTH     = 64,
  parameter int AXI_ID_WIDTH       = 4,
  parameter int MAX_BURST          = 8,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctrl_wen,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_waddr,
  input  logic [31:0]                ctrl_wdata,
  input  logic                       ctrl_ren,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_raddr,
  output logic [31:0]                ctrl_rdata,
  output logic                       ovalid,
  output logic [AXI_DATA_WIDTH-1:0]  odata,
  input  logic                       oready,
  output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arlock,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic [3:0]                 m_axi_arqos,
  output logic [3:0]                 m_axi_arregion,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int HW    = AXI_ADDR_WIDTH - 32;
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [CTRL_ADDR_WIDTH-1:0] A_CTRL  = CTRL_ADDR_WIDTH'(REGADDR_CTRL);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_BASEL = CTRL_ADDR_WIDTH'(REGADDR_BASEADDR_L);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_BASEH = CTRL_ADDR_WIDTH'(REGADDR_BASEADDR_H);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_LEN   = CTRL_ADDR_WIDTH'(REGADDR_LENGTH);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_STAT  = CTRL_ADDR_WIDTH'(REGADDR_STATUS);
  localparam logic [CTRL_ADDR_WIDTH-1:0] A_CNT   = CTRL_ADDR_WIDTH'(REGADDR_COUNT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             base_q, base_d;
  logic [31:0]               length_q, length_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      resp_err_q, resp_err_d;
  logic                      last_err_q, last_err_d;
  logic [31:0]               count_q, count_d;
  logic [29:0]               offset_q, offset_d;
  logic [31:0]               issued_q, issued_d;
  logic [8:0]                inflight_q, inflight_d;
  logic [8:0]                blen_q, blen_d;
  logic [AW-1:0]             araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PW:0]               occ_q, occ_d;
  logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] addr_s;
  logic [31:0]   remaining_s;
  logic [12:0]   bnd_beats_s;
  logic [8:0]    blen_a_s;
  logic [8:0]    blen_s;
  logic [31:0]   free_s;
  logic          can_issue_s;
  logic          start_s;
  logic          push_s;
  logic          pop_s;
  logic          last_beat_s;
  logic          go_ar_s;
  logic          unused_s;

  // Next burst: address, size limited by MAX_BURST, remaining beats and the
  // 4 KiB page, and the credit check against FIFO space not yet spoken for.
  assign addr_s      = base_q + AW'(offset_q);
  assign remaining_s = length_q - issued_q;
  assign bnd_beats_s = (13'h1000 - {1'b0, addr_s[11:0]}) >> SIZE;
  assign blen_a_s    = (remaining_s < 32'(MAX_BURST)) ? remaining_s[8:0] : 9'(MAX_BURST);
  assign blen_s      = ({4'd0, blen_a_s} > bnd_beats_s) ? bnd_beats_s[8:0] : blen_a_s;
  assign free_s      = 32'(FIFO_DEPTH) - 32'(occ_q) - 32'(inflight_q);
  assign can_issue_s = busy_q && (remaining_s != 32'd0) && (free_s >= 32'(blen_s));

  assign start_s     = ctrl_wen && (ctrl_waddr == A_CTRL) && ctrl_wdata[0] && !busy_q;
  assign push_s      = (state_q == S_R) && m_axi_rvalid && rready_q;
  assign pop_s       = (occ_q != {(PW+1){1'b0}}) && oready;
  assign last_beat_s = (inflight_q == 9'd1);
  assign unused_s    = ^m_axi_rid;

  assign ctrl_rdata     = rdata_q;
  assign ovalid         = (occ_q != {(PW+1){1'b0}});
  assign odata          = mem_q[rd_ptr_q];
  assign m_axi_arid     = {AXI_ID_WIDTH{1'b0}};
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = arlen_q;
  assign m_axi_arsize   = 3'(SIZE);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'd0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;

  // Register writes (frozen while busy) and the registered read mux.
  always_comb begin
    base_d   = base_q;
    length_d = length_q;
    rdata_d  = rdata_q;
    if (ctrl_wen && !busy_q) begin
      case (ctrl_waddr)
        A_BASEL: base_d[31:0]    = ctrl_wdata;
        A_BASEH: base_d[AW-1:32] = ctrl_wdata[HW-1:0];
        A_LEN:   length_d        = ctrl_wdata;
        default: base_d          = base_q;
      endcase
    end else begin
      base_d = base_q;
    end
    if (ctrl_ren) begin
      case (ctrl_raddr)
        A_CTRL:  rdata_d = 32'd0;
        A_BASEL: rdata_d = base_q[31:0];
        A_BASEH: rdata_d = 32'(base_q[AW-1:32]);
        A_LEN:   rdata_d = length_q;
        A_STAT:  rdata_d = {28'd0, last_err_q, resp_err_q, done_q, busy_q};
        A_CNT:   rdata_d = count_q;
        default: rdata_d = rdata_q;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Burst FSM, run bookkeeping, status flags and output-beat counter.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    resp_err_d = resp_err_q;
    last_err_d = last_err_q;
    count_d    = count_q;
    offset_d   = offset_q;
    issued_d   = issued_q;
    inflight_d = inflight_q;
    blen_d     = blen_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    rready_d   = 1'b1;
    go_ar_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_issue_s) go_ar_s = 1'b1;
        else             state_d = S_IDLE;
      end
      S_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_R;
          offset_d  = offset_q + (30'(blen_q) << SIZE);
          issued_d  = issued_q + 32'(blen_q);
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_R: begin
        if (push_s) begin
          inflight_d = inflight_q - 9'd1;
          if (last_beat_s != m_axi_rlast) last_err_d = 1'b1;
          else                            last_err_d = last_err_q;
          if (m_axi_rresp != 2'b00) resp_err_d = 1'b1;
          else                      resp_err_d = resp_err_q;
          // The burst ends on beat count; rlast is only checked.
          if (last_beat_s) begin
            if (can_issue_s) go_ar_s = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            state_d = S_R;
          end
        end else begin
          state_d = S_R;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
    if (go_ar_s) begin
      state_d    = S_AR;
      arvalid_d  = 1'b1;
      araddr_d   = addr_s;
      arlen_d    = 8'(blen_s - 9'd1);
      blen_d     = blen_s;
      inflight_d = blen_s;
    end else begin
      blen_d = blen_q;
    end
    if (pop_s) count_d = count_q + 32'd1;
    else       count_d = count_q;
    // Completion waits for the consumer to drain every beat.
    if (busy_q && (count_q == length_q)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else if (start_s) begin
      busy_d     = (length_q != 32'd0);
      done_d     = (length_q == 32'd0);
      resp_err_d = 1'b0;
      last_err_d = 1'b0;
      count_d    = 32'd0;
      offset_d   = 30'd0;
      issued_d   = 32'd0;
    end else begin
      busy_d = busy_q;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    if (push_s) wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    else        wr_ptr_d = wr_ptr_q;
    if (pop_s)  rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    else        rd_ptr_d = rd_ptr_q;
  end

  // State, configuration and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= {AW{1'b0}};
      length_q   <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
      last_err_q <= 1'b0;
      count_q    <= 32'd0;
      offset_q   <= 30'd0;
      issued_q   <= 32'd0;
      inflight_q <= 9'd0;
      blen_q     <= 9'd0;
      araddr_q   <= {AW{1'b0}};
      arlen_q    <= 8'd0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rdata_q    <= 32'd0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      occ_q      <= {(PW+1){1'b0}};
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      length_q   <= length_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      resp_err_q <= resp_err_d;
      last_err_q <= last_err_d;
      count_q    <= count_d;
      offset_q   <= offset_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      blen_q     <= blen_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rdata_q    <= rdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // FIFO storage: write the incoming R beat at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {AXI_DATA_WIDTH{1'b0}};
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= m_axi_rdata;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: doc/axi4_fifo_reader_ctrl.md
Name: axi4_fifo_reader_ctrl

Overview:
- AXI4 read-master counterpart of the trace writer: fetches a host-configured region of memory (base address + beat count) and streams it out on a valid/ready FIFO port in address order.
- Used by the trace backend to replay or read back trace buffers.
- Programmed through the same 32-bit ctrl register port style as the writer.
- Issues INCR bursts under a FIFO-credit rule, so rready can be held high permanently.

Parameters:
- REGADDR_CTRL, 0, ctrl register; write bit0=1 pulses start.
- REGADDR_BASEADDR_L, 4, base address bits [31:0].
- REGADDR_BASEADDR_H, 8, base address bits [AXI_ADDR_WIDTH-1:32].
- REGADDR_LENGTH, 12, total beats to read (32-bit).
- REGADDR_STATUS, 16, bit0 busy, bit1 done, bit2 resp_err, bit3 last_err.
- REGADDR_COUNT, 20, beats popped on the output port since start.
- CTRL_ADDR_WIDTH, 16, ctrl address width.
- AXI_ADDR_WIDTH, 36, AXI address width (>32).
- AXI_DATA_WIDTH, 64, AXI data width (power of 2, >=32).
- AXI_ID_WIDTH, 4, AXI ID width.
- MAX_BURST, 8, maximum beats per burst (1..256).
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=MAX_BURST).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ctrl_wen  in  1  register write strobe
- ctrl_waddr  in  CTRL_ADDR_WIDTH  write address
- ctrl_wdata  in  32  write data
- ctrl_ren  in  1  register read strobe
- ctrl_raddr  in  CTRL_ADDR_WIDTH  read address
- ctrl_rdata  out  32  registered read data
- ovalid  out  1  output data valid
- odata  out  AXI_DATA_WIDTH  output data
- oready  in  1  consumer ready
- m_axi_arid, araddr, arlen[8], arsize[3], arburst[2], arlock, arcache[4], arprot[3], arqos[4], arregion[4], arvalid  out  AR channel
- m_axi_arready  in  1
- m_axi_rid[ID], rdata[DATA], rresp[2], rlast, rvalid  in  R channel
- m_axi_rready  out  1

Behaviour:
- Reset (async assert, sync deassert) clears everything to 0: registers, FSM, FIFO, arvalid, ovalid, ctrl_rdata. rready resets to 0 and is 1 out of reset.
- Register reads: ctrl_rdata updates the cycle after ctrl_ren. Unmapped addresses hold the previous value. Registers are narrower than 32 bits and zero-extended.
- Writes to BASEADDR and LENGTH while busy are ignored.
- Start is ignored while busy. Start when idle:
  - clears done, resp_err, last_err, COUNT and the internal offset;
  - sets busy.
- Start with LENGTH==0: done=1 next cycle, busy stays 0, no AR issued.
- FSM states: IDLE, AR, R.
- IDLE->AR: busy, beats remaining to issue > 0, and FIFO free slots (FIFO_DEPTH - occupancy - in-flight) >= burst length.
- Burst length = min(MAX_BURST, remaining, beats to the next 4 KiB boundary).
- araddr = base + offset. offset advances by burst length * (AXI_DATA_WIDTH/8) on AR handshake and wraps modulo 2^30.
- AR: arvalid is held with stable payload until arready, then -> R.
- Fixed AR fields:
  - arlen = burst length - 1;
  - arsize = log2(AXI_DATA_WIDTH/8);
  - arburst = INCR;
  - arid, lock, cache, prot, qos, region = 0.
- R: every rvalid beat is pushed into the FIFO (space is guaranteed). The burst ends on beat count, not on rlast.
  - rlast mismatch on the final beat, or rlast asserted early, sets sticky last_err.
  - rresp != 0 sets sticky resp_err.
  - Data is delivered regardless of either error.
  - End of burst -> AR if more beats remain and credit allows, else IDLE.
- Only one burst is outstanding.
- Output port: first-word-fall-through; ovalid = FIFO non-empty.
  - Pop on ovalid && oready; COUNT increments per pop.
  - Simultaneous push and pop in one cycle is supported with no bubble.
- Completion: busy clears and done sets in the cycle after COUNT reaches LENGTH, i.e. only after the FIFO is drained.

Test Plan:
1. base=0x1000, LENGTH=4, oready=1 -> one AR with araddr=0x1000, arlen=3, arsize=3; 4 beats out in order; STATUS=0x2; COUNT=4.
2. base=0x2000, LENGTH=20 -> ARs at 0x2000/0x2040/0x2080 with arlen 7/7/3; 20 beats in order; done set.
3. base=0xFE0, LENGTH=16 -> ARs at 0xFE0 arlen=3, 0x1000 arlen=7, 0x1040 arlen=3; no burst crosses 4 KiB.
4. oready=0, LENGTH=40 -> FIFO fills to exactly 16; no AR issued while free < burst; rready stays 1.
   - Then raise oready -> all 40 beats out in order, none lost or duplicated.
5. rresp=2 on beat 3, and rlast=0 on a final beat -> STATUS bits 2 and 3 set, data still delivered; next start clears both.
6. Assert rst mid-R burst -> arvalid, ovalid and STATUS read 0 immediately.
   - After release, start with LENGTH=0 -> done next cycle with no AR.
